am_param_sequencer: RTL
=======================

AM_PARAM_SEQUENCER -- requirements
Module: am_param_sequencer

Interface
REQ-001 SHALL have parameter PHASE_WIDTH, default 32, width of the carrier phase increment word.
REQ-002 SHALL have parameter DEEP_WIDTH, default 16, width of the modulation-depth word.
REQ-003 SHALL have parameter DWELL_WIDTH, default 24, width of the per-step dwell count.
REQ-004 SHALL have parameter STEP_LOG2, default 3, giving a table of 2^STEP_LOG2 steps.
REQ-005 SHALL have port: clk_in  in  1  clock, all logic on the rising edge.
REQ-006 SHALL have port: RST  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port: wr_valid  in  1  table write request.
REQ-008 SHALL have port: wr_ready  out  1  table write accepted when high with wr_valid.
REQ-009 SHALL have port: wr_index  in  STEP_LOG2  table entry to write.
REQ-010 SHALL have port: wr_fre  in  PHASE_WIDTH  entry carrier increment.
REQ-011 SHALL have port: wr_deep  in  DEEP_WIDTH  entry modulation depth.
REQ-012 SHALL have port: wr_dwell  in  DWELL_WIDTH  entry dwell, in clk_in cycles.
REQ-013 SHALL have port: num_steps  in  STEP_LOG2+1  steps to run, sampled at start.
REQ-014 SHALL have port: start  in  1  begin sequence (level sampled in IDLE).
REQ-015 SHALL have port: stop  in  1  abort sequence.
REQ-016 SHALL have port: center_fre  out  PHASE_WIDTH  registered increment to the AM modulator.
REQ-017 SHALL have port: modulate_deep  out  DEEP_WIDTH  registered depth to the AM modulator.
REQ-018 SHALL have port: step_idx  out  STEP_LOG2  index of the active step.
REQ-019 SHALL have port: busy  out  1  high in any state except IDLE.
REQ-020 SHALL have port: done  out  1  one-cycle pulse at natural sequence end.

Function
REQ-021 SHALL implement FSM states IDLE, LOAD, DWELL, DONE.
REQ-022 wr_ready SHALL equal 1 only in IDLE; a write with wr_valid&wr_ready SHALL update table[wr_index] at that edge; writes while not ready SHALL be dropped.
REQ-023 IDLE->LOAD when start=1 and num_steps!=0; latch N=min(num_steps,2^STEP_LOG2), step_idx=0; start with num_steps=0 SHALL be ignored.
REQ-024 Write and start in the same IDLE cycle: the write SHALL be visible to the first LOAD.
REQ-025 LOAD (1 cycle) SHALL register table[step_idx] fre/deep onto center_fre/modulate_deep and set the dwell counter to max(dwell,1); next state DWELL.
REQ-026 DWELL SHALL decrement the counter each cycle; on reaching 1 the step SHALL end, so each step lasts exactly 1+max(dwell,1) cycles.
REQ-027 At step end, if step_idx<N-1: step_idx+1 and LOAD; else DONE (subject to REQ-034).
REQ-028 DONE SHALL assert done for one cycle then return to IDLE.
REQ-029 stop=1 in LOAD/DWELL/DONE SHALL force IDLE at the next edge with no done pulse; stop SHALL take priority over step advance.
REQ-030 center_fre/modulate_deep SHALL hold their last loaded values in IDLE, after done and after stop.
REQ-031 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-032 RST SHALL force IDLE, center_fre=0, modulate_deep=0, step_idx=0, busy=0, done=0, counter=0, all table entries=0; RST SHALL override every other input, including mid-sequence.

Configuration
REQ-033 Macro AM_SEQ_LOOP_EN SHALL, when defined, add input port loop_en (1 bit, sampled at start).
REQ-034 With AM_SEQ_LOOP_EN and loop_en latched 1, the last step SHALL wrap to step_idx=0 and LOAD, never reaching DONE until stop; without the macro the port SHALL be absent and the sequence SHALL be single-pass.

Verification
REQ-035 Write entries 0..2 (fre 0x1000/0x2000/0x3000, deep 0x4000/0x8000/0xFFFF, dwell 4/4/4), num_steps=3, start -> each value held 5 cycles, done pulse once 16 cycles after start, outputs hold 0x3000/0xFFFF.
REQ-036 dwell=0 on entry 0, num_steps=1 -> step lasts 2 cycles, then done.
REQ-037 stop asserted in 3rd DWELL cycle of step 1 -> IDLE next cycle, no done, outputs keep step-1 values, wr_ready=1.
REQ-038 wr_valid while busy -> entry unchanged on re-read; num_steps=0 with start -> busy stays 0.
REQ-039 RST mid-DWELL -> all outputs 0 next cycle, table cleared.
REQ-040 With AM_SEQ_LOOP_EN, loop_en=1, num_steps=2 -> step_idx 0,1,0,1... no done until stop.

Source files
------------

// File: rtl/am_param_sequencer.sv
// Table-driven AM parameter sequencer: steps through programmed carrier/depth/dwell entries.
// Optional build macro AM_SEQ_LOOP_EN adds a loop_en input that makes the sequence wrap until stopped.
module am_param_sequencer #(
  parameter int PHASE_WIDTH = 32,
  parameter int DEEP_WIDTH  = 16,
  parameter int DWELL_WIDTH = 24,
  parameter int STEP_LOG2   = 3
) (
  input  logic                   clk_in,
  input  logic                   RST,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [STEP_LOG2-1:0]   wr_index,
  input  logic [PHASE_WIDTH-1:0] wr_fre,
  input  logic [DEEP_WIDTH-1:0]  wr_deep,
  input  logic [DWELL_WIDTH-1:0] wr_dwell,
  input  logic [STEP_LOG2:0]     num_steps,
  input  logic                   start,
  input  logic                   stop,
`ifdef AM_SEQ_LOOP_EN
  input  logic                   loop_en,
`endif
  output logic [PHASE_WIDTH-1:0] center_fre,
  output logic [DEEP_WIDTH-1:0]  modulate_deep,
  output logic [STEP_LOG2-1:0]   step_idx,
  output logic                   busy,
  output logic                   done
);

  localparam int DEPTH = 1 << STEP_LOG2;
  localparam logic [STEP_LOG2:0] NSTEPS_MAX = (STEP_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, DWELL, DONE} state_t;

  state_t                 state;
  logic [PHASE_WIDTH-1:0] fre_tab   [DEPTH];
  logic [DEEP_WIDTH-1:0]  deep_tab  [DEPTH];
  logic [DWELL_WIDTH-1:0] dwell_tab [DEPTH];
  logic [DWELL_WIDTH-1:0] dwell_cnt;
  logic [STEP_LOG2-1:0]   last_idx;
  logic [STEP_LOG2:0]     num_m1;
  logic                   loop_active;

  assign num_m1 = num_steps - 1'b1;

`ifdef AM_SEQ_LOOP_EN
  logic loop_q;
  assign loop_active = loop_q;
`else
  assign loop_active = 1'b0;
`endif

  // NOTE: the table is cleared by reset, so it must live in flops rather than an
  // inferred RAM; a RAM macro cannot be reset in a single cycle.
  always_ff @(posedge clk_in) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        fre_tab[i]   <= '0;
        deep_tab[i]  <= '0;
        dwell_tab[i] <= '0;
      end
    end else if (wr_valid && wr_ready) begin
      fre_tab[wr_index]   <= wr_fre;
      deep_tab[wr_index]  <= wr_deep;
      dwell_tab[wr_index] <= wr_dwell;
    end
  end

  // wr_ready and busy are kept as flops beside the state so every output is registered.
  always_ff @(posedge clk_in) begin
    if (RST) begin
      state         <= IDLE;
      center_fre    <= '0;
      modulate_deep <= '0;
      step_idx      <= '0;
      last_idx      <= '0;
      dwell_cnt     <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      wr_ready      <= 1'b1;
`ifdef AM_SEQ_LOOP_EN
      loop_q        <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && (num_steps != '0)) begin
            state    <= LOAD;
            step_idx <= '0;
            last_idx <= (num_steps > NSTEPS_MAX) ? '1 : num_m1[STEP_LOG2-1:0];
            busy     <= 1'b1;
            wr_ready <= 1'b0;
`ifdef AM_SEQ_LOOP_EN
            loop_q   <= loop_en;
`endif
          end
        end
        LOAD: begin
          if (stop) begin
            state    <= IDLE;
            busy     <= 1'b0;
            wr_ready <= 1'b1;
          end else begin
            center_fre    <= fre_tab[step_idx];
            modulate_deep <= deep_tab[step_idx];
            dwell_cnt     <= (dwell_tab[step_idx] == '0) ? DWELL_WIDTH'(1) : dwell_tab[step_idx];
            state         <= DWELL;
          end
        end
        DWELL: begin
          if (stop) begin
            state    <= IDLE;
            busy     <= 1'b0;
            wr_ready <= 1'b1;
          end else if (dwell_cnt == DWELL_WIDTH'(1)) begin
            if (step_idx != last_idx) begin
              step_idx <= step_idx + 1'b1;
              state    <= LOAD;
            end else if (loop_active) begin
              step_idx <= '0;
              state    <= LOAD;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end else begin
            dwell_cnt <= dwell_cnt - 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          wr_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
